usr_burst: RTL and testbench
============================

// Module: usr_burst
// PURPOSE
//  Parametrised universal shift register with an op-coded burst engine.
//  A single start pulse performs LOAD, CLR or a multi-step shift/rotate of AMT steps, one step per clock.
//  busy/done handshake lets a controller sequence bursts.
//  Next-generation replacement for the fixed 4-bit SISO/SIPO/PISO/PIPO register in serial/parallel datapaths.
// PARAMETERS
//  N      8  register width in bits (N >= 2)
//  CNT_W  4  width of burst-length field; max burst = 2**CNT_W-1 steps
// PORTS
//  clk    in   1      rising-edge clock
//  rst    in   1      asynchronous, active-low reset
//  start  in   1      request; sampled only in IDLE
//  op     in   3      operation, sampled with start
//  amt    in   CNT_W  number of shift steps, sampled with start
//  pin    in   N      parallel load data, sampled with start (LOAD)
//  sin_r  in   1      serial in to bit 0 on SHL; sampled live each step
//  sin_l  in   1      serial in to bit N-1 on SHR; sampled live each step
//  pout   out  N      register contents
//  sout_l out  1      pout[N-1], combinational from register
//  sout_r out  1      pout[0], combinational from register
//  busy   out  1      high while state != IDLE
//  done   out  1      one-cycle pulse in the final cycle of an operation
// BEHAVIOUR
//  Op codes:
//   0 HOLD
//   1 LOAD (pin)
//   2 SHL (LSB<=sin_r)
//   3 SHR (MSB<=sin_l)
//   4 ROL
//   5 ROR
//   6 ASR (MSB replicated)
//   7 CLR (all 0)
//  Reset (rst=0, async): pout=0, state=IDLE, step counter=0, busy=0, done=0.
//   Reset mid-burst aborts immediately.
//   No done pulse is issued for an aborted burst.
//  FSM states: IDLE, RUN, DONE.
//  IDLE, start=0: pout holds.
//  IDLE, start=1, at edge E0:
//   - op in {HOLD, LOAD, CLR}, or amt==0: apply the action (HOLD/amt==0 leave pout unchanged); go to DONE.
//   - Shift op, amt>=1: perform step 1 at E0; cnt<=amt-1.
//     Go to DONE if amt==1, else go to RUN.
//  RUN: each edge performs one step and decrements cnt.
//   The step taken with cnt==1 moves the FSM to DONE.
//  DONE: done=1 for exactly one cycle; next edge returns to IDLE.
//   start is ignored in DONE.
//  Burst of amt>=1 steps: busy high for exactly amt cycles, done on the last of them.
//   Single-cycle ops: busy and done high for 1 cycle.
//  start while busy: ignored, not queued; op/amt/pin changes are ignored.
//  Latched op and amt are held constant through the burst.
//  sin_l and sin_r are not latched; their value at each step edge is used.
//  Rotates with amt>=N wrap naturally: ROL/ROR by N restores the original value.
//  Back-to-back ops: earliest next start is the cycle after done (IDLE).
//  All arithmetic is unsigned on CNT_W bits; the counter never underflows.
// TESTING (N=8, CNT_W=4)
//  1. Drive rst=0 during a RUN burst -> pout=8'h00, busy=0, done=0 without waiting for a clock edge.
//     No done pulse follows the abort.
//  2. LOAD, pin=8'hB4, start 1 cycle -> pout=8'hB4 after E0; busy=done=1 for 1 cycle; then IDLE.
//  3. From 8'hB4: SHL amt=3, sin_r=1 -> pout=8'hA7 after 3 edges.
//     busy high 3 cycles; done in 3rd; sout_l=1, sout_r=1.
//  4. From 8'hA7: ROR amt=8 -> pout=8'hA7; busy 8 cycles; done in 8th.
//  5. LOAD 8'h90, then ASR amt=2 -> pout=8'hE4.
//     Then SHR amt=1 with sin_l=0 -> pout=8'h72.
//  6. Pulse start with CLR while a SHL amt=5 burst is busy -> ignored; burst completes normally.
//     Then SHL amt=0 -> pout unchanged, done pulses one cycle after start.

Source files
------------

// File: rtl/usr_burst.sv
// usr_burst: parametrised universal shift register with an op-coded burst engine.
//
// One start pulse runs one whole operation. The operation is LOAD, CLR, HOLD,
// or a shift/rotate of amt steps taken one per clock. The busy/done handshake
// lets a controller sequence bursts back to back.
//
// Ports:
//   clk    - rising-edge clock
//   rst    - asynchronous, active-low reset
//   start  - operation request, sampled only in IDLE
//   op     - operation code, sampled with start
//            (0 HOLD, 1 LOAD, 2 SHL, 3 SHR, 4 ROL, 5 ROR, 6 ASR, 7 CLR)
//   amt    - number of shift steps, sampled with start
//   pin    - parallel load data, sampled with start
//   sin_r  - serial input into bit 0 on SHL, used live at every step
//   sin_l  - serial input into bit N-1 on SHR, used live at every step
//   pout   - register contents
//   sout_l - pout[N-1]
//   sout_r - pout[0]
//   busy   - high while the engine is not idle
//   done   - one-cycle pulse in the final cycle of an operation
module usr_burst #(
  parameter int N     = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [CNT_W-1:0] amt,
  input  logic [N-1:0]     pin,
  input  logic             sin_r,
  input  logic             sin_l,
  output logic [N-1:0]     pout,
  output logic             sout_l,
  output logic             sout_r,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] OP_HOLD = 3'd0;
  localparam logic [2:0] OP_LOAD = 3'd1;
  localparam logic [2:0] OP_SHL  = 3'd2;
  localparam logic [2:0] OP_SHR  = 3'd3;
  localparam logic [2:0] OP_ROL  = 3'd4;
  localparam logic [2:0] OP_ROR  = 3'd5;
  localparam logic [2:0] OP_ASR  = 3'd6;
  localparam logic [2:0] OP_CLR  = 3'd7;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_next;
  logic [N-1:0]     reg_q, reg_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [2:0]       op_q, op_next;
  logic [2:0]       step_op;
  logic [N-1:0]     stepped;
  logic             start_is_shift;

  // One step of a shift or rotate. Non-shift codes return the value unchanged.
  function automatic logic [N-1:0] shift_step(input logic [2:0] code,
                                              input logic [N-1:0] v,
                                              input logic sr,
                                              input logic sl);
    logic [N-1:0] r;
    r = v;
    case (code)
      OP_SHL:  r = {v[N-2:0], sr};
      OP_SHR:  r = {sl, v[N-1:1]};
      OP_ROL:  r = {v[N-2:0], v[N-1]};
      OP_ROR:  r = {v[0], v[N-1:1]};
      OP_ASR:  r = {v[N-1], v[N-1:1]};
      default: r = v;
    endcase
    return r;
  endfunction

  // State, data register, step counter and latched op. Reset aborts any
  // burst immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      reg_q <= '0;
      cnt   <= '0;
      op_q  <= OP_HOLD;
    end else begin
      state <= state_next;
      reg_q <= reg_next;
      cnt   <= cnt_next;
      op_q  <= op_next;
    end
  end

  // Next-state logic. The first step of a burst is taken on the start edge
  // itself, using the live op. The remaining steps use the latched op.
  always_comb begin
    state_next     = state;
    reg_next       = reg_q;
    cnt_next       = cnt;
    op_next        = op_q;
    step_op        = (state == IDLE) ? op : op_q;
    stepped        = shift_step(step_op, reg_q, sin_r, sin_l);
    start_is_shift = (op >= OP_SHL) && (op <= OP_ASR) && (amt != '0);

    case (state)
      IDLE: begin
        if (start) begin
          op_next = op;
          if (start_is_shift) begin
            reg_next   = stepped;
            cnt_next   = amt - CNT_W'(1);
            state_next = (amt == CNT_W'(1)) ? DONE : RUN;
          end else begin
            if (op == OP_LOAD) begin
              reg_next = pin;
            end else if (op == OP_CLR) begin
              reg_next = '0;
            end
            cnt_next   = '0;
            state_next = DONE;
          end
        end
      end
      RUN: begin
        // RUN is only entered with cnt >= 1, so this cannot underflow.
        reg_next = stepped;
        cnt_next = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          state_next = DONE;
        end
      end
      DONE: begin
        cnt_next   = '0;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign pout   = reg_q;
  assign sout_l = reg_q[N-1];
  assign sout_r = reg_q[0];
  assign busy   = (state != IDLE);
  assign done   = (state == DONE);

endmodule

// File: tb/tb_usr_burst.sv
// tb_usr_burst: scoreboard testbench for usr_burst with N=8 and CNT_W=4.
//
// Each operation that is expected to complete pushes one expected result
// into a queue. The expected result holds the final pout, the number of busy
// cycles, and the serial outputs. A monitor pops one entry at every done
// pulse and compares it. Reset and abort behaviour is checked directly.
module tb_usr_burst;

  logic       clk;
  logic       rst;
  logic       start;
  logic [2:0] op;
  logic [3:0] amt;
  logic [7:0] pin;
  logic       sin_r;
  logic       sin_l;
  logic [7:0] pout;
  logic       sout_l;
  logic       sout_r;
  logic       busy;
  logic       done;

  typedef struct {
    logic [7:0] pout;
    int         cycles;
    logic       sl;
    logic       sr;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   busy_cnt = 0;

  usr_burst #(.N(8), .CNT_W(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .amt    (amt),
    .pin    (pin),
    .sin_r  (sin_r),
    .sin_l  (sin_l),
    .pout   (pout),
    .sout_l (sout_l),
    .sout_r (sout_r),
    .busy   (busy),
    .done   (done)
  );

  // Free-running clock with a 10-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compares one observed value against its expected value and counts the result.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 'h%0h expected 'h%0h", name, actual, expected);
    end
  endtask

  // Issues one start pulse. When the operation is expected to finish, the
  // expected outcome is queued first.
  task automatic applyStimulus(input logic [2:0] o, input logic [3:0] a,
                               input logic [7:0] p, input logic [7:0] exp_pout,
                               input int exp_cycles, input bit expect_done);
    exp_t e;
    @(negedge clk);
    if (expect_done) begin
      e.pout   = exp_pout;
      e.cycles = exp_cycles;
      e.sl     = exp_pout[7];
      e.sr     = exp_pout[0];
      exp_q.push_back(e);
    end
    start = 1'b1;
    op    = o;
    amt   = a;
    pin   = p;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Waits until busy drops, with a cycle bound. Running out of cycles
  // counts as a failed check.
  task automatic waitIdle();
    int n;
    n = 0;
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("[TB] FAIL wait_idle: busy still 1 after %0d cycles, required 0", n);
    end
  endtask

  // Monitor: counts busy cycles and checks each done pulse against the queue.
  always @(negedge clk) begin
    if (!rst) begin
      busy_cnt = 0;
    end else begin
      if (busy) busy_cnt++;
      if (done) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_done: done=1 with no expected result queued, required none");
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          checkOutput("done_pout", 32'(pout), 32'(e.pout));
          checkOutput("busy_cycles", 32'(busy_cnt), 32'(e.cycles));
          checkOutput("sout_l", 32'(sout_l), 32'(e.sl));
          checkOutput("sout_r", 32'(sout_r), 32'(e.sr));
        end
        busy_cnt = 0;
      end
    end
  end

  initial begin
    rst   = 1'b0;
    start = 1'b0;
    op    = 3'd0;
    amt   = 4'd0;
    pin   = 8'h00;
    sin_r = 1'b0;
    sin_l = 1'b0;

    #1;
    checkOutput("reset_pout", 32'(pout), 32'h00);
    checkOutput("reset_busy", 32'(busy), 32'h0);
    checkOutput("reset_done", 32'(done), 32'h0);
    checkOutput("reset_sout_l", 32'(sout_l), 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Abort a long rotate partway through. Reset clears the outputs without
    // waiting for a clock edge, and no done pulse follows.
    applyStimulus(3'd1, 4'd0, 8'hFF, 8'hFF, 1, 1'b1);
    waitIdle();
    applyStimulus(3'd4, 4'd10, 8'h00, 8'h00, 0, 1'b0);
    repeat (2) @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("abort_pout", 32'(pout), 32'h00);
    checkOutput("abort_busy", 32'(busy), 32'h0);
    checkOutput("abort_done", 32'(done), 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    checkOutput("post_abort_busy", 32'(busy), 32'h0);

    // LOAD completes in a single cycle.
    applyStimulus(3'd1, 4'd0, 8'hB4, 8'hB4, 1, 1'b1);
    waitIdle();

    // SHL by 3 with sin_r=1: B4 -> 69 -> D3 -> A7.
    sin_r = 1'b1;
    applyStimulus(3'd2, 4'd3, 8'h00, 8'hA7, 3, 1'b1);
    waitIdle();
    sin_r = 1'b0;

    // ROR by 8 restores the original value.
    applyStimulus(3'd5, 4'd8, 8'h00, 8'hA7, 8, 1'b1);
    waitIdle();

    // ASR by 2: 90 -> C8 -> E4. sin_l=0 so a plain SHR would differ.
    applyStimulus(3'd1, 4'd0, 8'h90, 8'h90, 1, 1'b1);
    waitIdle();
    applyStimulus(3'd6, 4'd2, 8'h00, 8'hE4, 2, 1'b1);
    waitIdle();
    applyStimulus(3'd3, 4'd1, 8'h00, 8'h72, 1, 1'b1);
    waitIdle();

    // SHL by 5 from 72 gives 40. A CLR start pulsed mid-burst is ignored.
    applyStimulus(3'd2, 4'd5, 8'h00, 8'h40, 5, 1'b1);
    @(negedge clk);
    start = 1'b1;
    op    = 3'd7;
    amt   = 4'd3;
    pin   = 8'hFF;
    @(negedge clk);
    start = 1'b0;
    op    = 3'd0;
    waitIdle();

    // SHL by 0 leaves pout unchanged and finishes in a single cycle.
    applyStimulus(3'd2, 4'd0, 8'h00, 8'h40, 1, 1'b1);
    waitIdle();

    repeat (3) @(negedge clk);
    checkOutput("queue_empty", 32'(exp_q.size()), 32'h0);
    checkOutput("final_pout", 32'(pout), 32'h40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
